// File: rtl/rv_fetch_pkg.sv
// rtl/rv_fetch_pkg.sv - shared types and constants for the instruction fetch stage
package rv_fetch_pkg;

    localparam int XLEN = 32;

    // addi x0,x0,0
    localparam logic [XLEN-1:0] RV_NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_VALID = 3'd3,
        ST_DRAIN = 3'd4
    } fetch_state_e;

    // Memory is word-addressed from the fetch point of view; low PC bits never reach it.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/rv_fetch_timeout_ctr.sv
// rtl/rv_fetch_timeout_ctr.sv - saturating cycle counter shared by the WAIT and DRAIN states
module rv_fetch_timeout_ctr #(
    parameter int MAX = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int W = (MAX < 1) ? 1 : $clog2(MAX + 1);
    localparam logic [W-1:0] SAT  = W'(MAX);
    localparam logic [W-1:0] LAST = W'(MAX - 1);

    logic [W-1:0] count_q, count_d;

    // Count enabled cycles, hold at MAX, restart whenever the owner leaves WAIT/DRAIN.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != SAT)) begin
            count_d = count_q + W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // The current enabled cycle is the MAX-th one, so the owner leaves after exactly MAX cycles.
    assign expired_o = en_i && (count_q >= LAST);

endmodule

// File: rtl/rv_instr_fetch.sv
// rtl/rv_instr_fetch.sv - single-outstanding instruction fetch stage; build macro FETCH_MISALIGN_CHK_EN
module rv_instr_fetch
    import rv_fetch_pkg::*;
#(
    parameter int              TIMEOUT_CYCLES = 255,
    parameter logic [XLEN-1:0] NOP_INSTR      = RV_NOP
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic [XLEN-1:0] pc_curr,
    input  logic            flush,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic            fetch_err,
    output logic            fetch_hlt
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    output logic            fetch_misalign
`endif
);
    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;
    logic            err_q, err_d;
    logic            load, load_nop, load_err;
    logic            misalign;
    logic            ctr_en, expired;

`ifdef FETCH_MISALIGN_CHK_EN
    assign misalign = (pc_curr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // WAIT and DRAIN share one counter; a WAIT->DRAIN flush keeps the elapsed time of the request.
    assign ctr_en = (state_q == ST_WAIT) || (state_q == ST_DRAIN);

    rv_fetch_timeout_ctr #(
        .MAX (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i     (sys_clk),
        .rst_i     (sys_rst),
        .clr_i     (!ctr_en),
        .en_i      (ctr_en),
        .expired_o (expired)
    );

    // Next state and hold-register load decision; flush outranks every other event.
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        load_nop = 1'b0;
        load_err = 1'b0;
        case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                if (flush) begin
                    // A misaligned PC issued nothing, so there is nothing to drain.
                    state_d = (imem_rvalid || misalign) ? ST_REQ : ST_DRAIN;
                end else if (misalign) begin
                    state_d  = ST_VALID;
                    load     = 1'b1;
                    load_nop = 1'b1;
                end else if (imem_rvalid) begin
                    state_d = ST_VALID;
                    load    = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    state_d = imem_rvalid ? ST_REQ : ST_DRAIN;
                end else if (imem_rvalid) begin
                    state_d = ST_VALID;
                    load    = 1'b1;
                end else if (expired) begin
                    state_d  = ST_VALID;
                    load     = 1'b1;
                    load_nop = 1'b1;
                    load_err = 1'b1;
                end
            end
            ST_VALID: begin
                if (flush || instr_ready) begin
                    state_d = ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (imem_rvalid || expired) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        err_d      = err_q;
        if (load) begin
            instr_d    = load_nop ? NOP_INSTR : imem_rdata;
            instr_pc_d = pc_curr;
            err_d      = load_err;
        end
    end

    // State and held-instruction registers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= ST_IDLE;
            instr_q    <= NOP_INSTR;
            instr_pc_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            err_q      <= err_d;
        end
    end

`ifdef FETCH_MISALIGN_CHK_EN
    logic mis_q, mis_d;

    assign mis_d = load ? ((state_q == ST_REQ) && misalign) : mis_q;

    // Misalign flag follows the held word and clears on the next load.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= mis_d;
        end
    end

    assign fetch_misalign = mis_q;
`endif

    assign imem_req    = (state_q == ST_REQ) && !misalign;
    assign imem_addr   = word_align(pc_curr);
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = (state_q == ST_VALID);
    assign fetch_err   = err_q;
    // PC may move only when decode takes the word or execute redirects.
    assign fetch_hlt   = !(((state_q == ST_VALID) && instr_ready) || flush);

endmodule

// File: tb/tb_rv_instr_fetch.sv
// tb/tb_rv_instr_fetch.sv - self-checking bench for rv_instr_fetch
module tb_rv_instr_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_MISALIGN_CHK_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [31:0] pc_curr;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        fetch_err;
    logic        fetch_hlt;
`ifdef FETCH_MISALIGN_CHK_EN
    logic        fetch_misalign;
`endif

    always #5 sys_clk = ~sys_clk;

    rv_instr_fetch #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .pc_curr     (pc_curr),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .fetch_err   (fetch_err),
        .fetch_hlt   (fetch_hlt)
`ifdef FETCH_MISALIGN_CHK_EN
        ,
        .fetch_misalign (fetch_misalign)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Bench-side program counter and single-slot memory responder.
    logic [31:0] pc = '0;
    logic [31:0] cur_pc;
    bit          pend = 0;
    int          p_cnt, p_lat;
    logic [31:0] p_addr;
    logic [31:0] rq_pc, rq_ins;
    logic        rq_err;

    logic        s_req, s_valid, s_err, s_hlt;
    logic [31:0] s_addr, s_instr, s_pc;

    typedef struct {
        bit          rst, fl, rdy;
        logic [31:0] tgt;
        int          lat;
        bit          ev, eh, er;
        logic [31:0] eaddr, epc, ein;
        bit          eerr;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [31:0] memf(input logic [31:0] a);
        return 32'h1000_0000 + a;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic add(input bit rst, input bit fl, input bit rdy, input logic [31:0] tgt, input int lat,
                       input bit ev, input bit eh, input bit er, input logic [31:0] eaddr,
                       input logic [31:0] epc, input logic [31:0] ein, input bit eerr);
        vec_t v;
        v.rst = rst; v.fl = fl; v.rdy = rdy; v.tgt = tgt; v.lat = lat;
        v.ev = ev; v.eh = eh; v.er = er; v.eaddr = eaddr; v.epc = epc; v.ein = ein; v.eerr = eerr;
        tbl.push_back(v);
    endtask

    // One clock: drive, let memory answer, sample, then advance the PC as a real PC would.
    task automatic tick(input bit rst, input bit fl, input bit rdy, input logic [31:0] tgt, input int lat);
        @(negedge sys_clk);
        sys_rst = rst; flush = fl; instr_ready = rdy; pc_curr = pc;
        imem_rvalid = 1'b0; imem_rdata = 32'hBAD0_BAD0;
        #1;
        s_req = imem_req; s_addr = imem_addr;
        if (imem_req) begin
            pend = 1; p_cnt = 0; p_lat = lat; p_addr = imem_addr;
            rq_pc = pc; rq_ins = (lat < 0) ? NOP : memf(imem_addr); rq_err = (lat < 0);
        end
        if (pend && p_lat >= 0 && p_cnt == p_lat) begin
            imem_rvalid = 1'b1; imem_rdata = memf(p_addr); pend = 0;
        end
        #1;
        s_valid = instr_valid; s_instr = instr; s_pc = instr_pc; s_err = fetch_err; s_hlt = fetch_hlt;
        if (pend) p_cnt++;
        cur_pc = pc;
        if (rst) pc = '0;
        else if (!s_hlt) pc = fl ? tgt : pc + 32'd4;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idle;
        sys_rst = 1'b1; flush = 1'b0; instr_ready = 1'b0; pc_curr = '0;
        imem_rvalid = 1'b0; imem_rdata = '0;

        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        chk("rst_valid", {31'd0, s_valid}, 32'd0);
        chk("rst_instr", s_instr, NOP);
        chk("rst_pc", s_pc, 32'd0);
        chk("rst_err", {31'd0, s_err}, 32'd0);
        chk("rst_req", {31'd0, s_req}, 32'd0);

        // rst fl rdy tgt lat | ev eh er eaddr epc ein eerr
        add(0,0,1,0,0, 0,1,0, 0,0,0,0);
        for (int k = 0; k < 3; k++) begin
            add(0,0,1,0,0, 0,1,1, 4*k,0,0,0);
            add(0,0,1,0,0, 1,0,0, 0,4*k,memf(4*k),0);
        end
        add(0,0,0,0,3, 0,1,1, 'hC,0,0,0);
        for (int k = 0; k < 3; k++) add(0,0,0,0,3, 0,1,0, 0,0,0,0);
        for (int k = 0; k < 5; k++) add(0,0,0,0,0, 1,1,0, 0,'hC,memf('hC),0);
        add(0,0,1,0,0, 1,0,0, 0,'hC,memf('hC),0);
        add(0,0,0,0,-1, 0,1,1, 'h10,0,0,0);
        for (int k = 0; k < 4; k++) add(0,0,0,0,-1, 0,1,0, 0,0,0,0);
        add(0,0,1,0,0, 1,0,0, 0,'h10,NOP,1);
        add(0,0,0,0,3, 0,1,1, 'h14,0,0,0);
        add(0,1,0,'h40,3, 0,0,0, 0,0,0,0);
        add(0,0,0,0,3, 0,1,0, 0,0,0,0);
        add(0,0,0,0,3, 0,1,0, 0,0,0,0);
        add(0,0,0,0,1, 0,1,1, 'h40,0,0,0);
        add(0,0,0,0,1, 0,1,0, 0,0,0,0);
        add(0,0,1,0,0, 1,0,0, 0,'h40,memf('h40),0);
        add(0,0,0,0,0, 0,1,1, 'h44,0,0,0);
        add(0,1,1,'h80,0, 1,0,0, 0,'h44,memf('h44),0);
        add(0,0,0,0,0, 0,1,1, 'h80,0,0,0);
        add(0,0,1,0,0, 1,0,0, 0,'h80,memf('h80),0);
        add(0,1,0,'h100,0, 0,0,1, 'h84,0,0,0);
        add(0,0,0,0,0, 0,1,1, 'h100,0,0,0);
        add(0,0,1,0,0, 1,0,0, 0,'h100,memf('h100),0);
        add(0,0,0,0,3, 0,1,1, 'h104,0,0,0);
        add(0,0,0,0,3, 0,1,0, 0,0,0,0);
        add(1,0,0,0,3, 0,1,0, 0,0,0,0);
        add(0,0,0,0,0, 0,1,0, 0,0,0,0);
        add(0,0,0,0,0, 0,1,1, 0,0,0,0);
        add(0,1,1,'h6,0, 1,0,0, 0,0,memf(0),0);
        add(0,0,0,0,0, 0,1,!MIS, 'h4,0,0,0);
        add(0,0,1,0,0, 1,0,0, 0,'h6,MIS ? NOP : memf('h4),0);

        foreach (tbl[i]) begin
            tick(tbl[i].rst, tbl[i].fl, tbl[i].rdy, tbl[i].tgt, tbl[i].lat);
            chk($sformatf("v%0d_valid", i), {31'd0, s_valid}, {31'd0, tbl[i].ev});
            chk($sformatf("v%0d_hlt", i), {31'd0, s_hlt}, {31'd0, tbl[i].eh});
            chk($sformatf("v%0d_req", i), {31'd0, s_req}, {31'd0, tbl[i].er});
            if (tbl[i].er) chk($sformatf("v%0d_addr", i), s_addr, tbl[i].eaddr);
            if (tbl[i].ev) begin
                chk($sformatf("v%0d_pc", i), s_pc, tbl[i].epc);
                chk($sformatf("v%0d_instr", i), s_instr, tbl[i].ein);
                chk($sformatf("v%0d_err", i), {31'd0, s_err}, {31'd0, tbl[i].eerr});
            end
        end

        // Randomized traffic against the scoreboard: each delivered word belongs to the latest request.
        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        idle = 0;
        for (int c = 0; c < 2000; c++) begin
            bit          fl, rdy;
            logic [31:0] tgt;
            int          lat;
            fl  = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            tgt = $urandom & 32'h0000_0FFC;
            lat = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 3));
            tick(0, fl, rdy, tgt, lat);
            chk($sformatf("r%0d_hlt", c), {31'd0, s_hlt}, {31'd0, !((s_valid && rdy) || fl)});
            if (s_req) chk($sformatf("r%0d_addr", c), s_addr, {cur_pc[31:2], 2'b00});
            if (s_valid) begin
                chk($sformatf("r%0d_pc", c), s_pc, rq_pc);
                chk($sformatf("r%0d_pcheld", c), s_pc, cur_pc);
                chk($sformatf("r%0d_instr", c), s_instr, rq_ins);
                chk($sformatf("r%0d_err", c), {31'd0, s_err}, {31'd0, rq_err});
                idle = 0;
            end else begin
                idle++;
            end
            if (idle > 100) begin
                checks++;
                errors++;
                $display("FAIL r_progress actual=%0d idle cycles expected<=100", idle);
                break;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
